z80fi_recorder: RTL and testbench
=================================

# z80fi_recorder

Core-side producer of the Z80FI retirement record. Watches the core's instruction, M-cycle and T-state strobes plus its architectural register snapshot, assembles one record per executed instruction, and presents it on the `z80fi_*` bus that all `z80fi_insn_spec_*` checkers consume. It sits between the core and the formal harness and contains no checking logic of its own.

## Interface

Parameters:
- `MAX_MCYCLES`, 6: number of M-cycle slots per record (type + T-count each).
- `MAX_INSN_BYTES`, 4: opcode/operand bytes captured per instruction.

Ports:
- `clk`  in  1  core clock; one clock = one T-state.
- `reset`  in  1  synchronous, active-high.
- `core_insn_start`  in  1  first T1 of an instruction's first M1; always coincident with `core_mcycle_start`.
- `core_mcycle_start`  in  1  T1 of an M-cycle.
- `core_mcycle_type`  in  3  `CYCLE_*` encoding from z80.vh, valid with `core_mcycle_start`.
- `core_insn_byte_valid`  in  1  an instruction byte (opcode, prefix, displacement, immediate) is fetched this clock.
- `core_insn_byte`  in  8  that byte.
- `core_regs`  in  128  architectural state: {ip, sp, ix, iy, a, f, b, c, d, e, h, l}, ip in [127:112], l in [7:0].
- `z80fi_valid`  out  1  one-clock record strobe.
- `z80fi_insn`  out  32  captured bytes, first byte in [7:0].
- `z80fi_insn_len`  out  3  byte count, 0..4.
- `z80fi_regs_in` / `z80fi_regs_out`  out  128 each  state before / after the instruction, same packing as `core_regs`.
- `z80fi_mcycle_type1..6`  out  3 each  M-cycle types in order.
- `z80fi_tcycles1..6`  out  4 each  T-states per M-cycle.
- `z80fi_overflow`  out  1  record exceeded a slot/byte limit; record is not trustworthy.

## Operation

- State machine: IDLE, RUN.
- IDLE, `core_insn_start`=1: latch `regs_in`<=`core_regs`; clear byte buffer, length, slot array, overflow; slot index<=0, slot0 type<=`core_mcycle_type`, slot0 T-count<=1; go RUN. No record emitted.
- RUN, `core_insn_start`=1: finalize current record (regs_out<=`core_regs` this clock), drive it to outputs, then restart capture exactly as from IDLE in the same clock. Stays RUN.
- RUN, `core_mcycle_start`=1 without insn_start: slot index+1; new slot type<=`core_mcycle_type`, T-count<=1. If index would reach `MAX_MCYCLES`: set overflow, further slots dropped, last slot's T-count frozen.
- RUN, any other clock: current slot T-count+1, saturating at 15.
- `core_insn_byte_valid`=1: byte stored at position len, len+1. At len=4, byte dropped and overflow set. A byte strobe on an insn_start clock belongs to the new instruction.
- Unused slots report `CYCLE_NONE` and T-count 0; unused insn bytes read 0.
- The core presents `core_regs` as the committed state of the previous instruction on every insn_start clock; the recorder does not interpret registers.
- `core_mcycle_start` in IDLE without insn_start: ignored.

## Timing

- Reset: `z80fi_valid`=0, all record outputs 0 (`CYCLE_NONE` types, len 0, overflow 0), state IDLE, internal buffers cleared.
- Reset mid-instruction: partial record discarded, no valid pulse; first record after reset is emitted only after two insn_starts.
- Latency: `z80fi_valid` high the clock after the terminating `core_insn_start`, for exactly one clock.
- Record outputs are registered and hold their values until the next valid pulse.
- The terminating insn_start clock is not counted in the old record's T-states.
- Minimum instruction length (back-to-back insn_starts one clock apart) is supported: one valid per clock, each with tcycles1=1.
- No backpressure; consumer must sample on valid.

## Test plan

- NOP: insn_start+M1 at clk0, byte 0x00 at clk1, insn_start clk4 -> valid clk5, insn=0x00000000, len=1, type1=M1, tcycles1=4, type2=NONE, tcycles2=0.
- EX DE,HL: regs d=0x12 e=0x34 h=0x56 l=0x78 at first insn_start, core presents swapped at next -> regs_in/regs_out show swap, insn=0xEB, len=1, tcycles1=4.
- LD A,(0x1234): bytes 3A,34,12; M-cycles M1(4), mem-read(3), mem-read(3), mem-read(3) -> insn=0x0012343A, len=3, four slots with tcycles 4,3,3,3, slots 5-6 NONE/0.
- Overflow: 7 mcycle_starts and 5 bytes in one instruction -> overflow=1, len=4, first four bytes kept, slot6 type from sixth M-cycle.
- Reset asserted mid-instruction, then two insn_starts 4 clocks apart -> no valid before the second insn_start, one valid after, with regs_in sampled after reset.
- Back-to-back: insn_starts on 3 consecutive clocks -> valid on two consecutive clocks, each tcycles1=1, first-to-second regs_out equals second's regs_in.

Source files
------------

// File: rtl/z80fi_recorder.sv
// Z80FI retirement-record producer: assembles one record per executed
// instruction from core strobes and presents it on the z80fi_* bus.
module z80fi_recorder #(
    parameter int MAX_MCYCLES    = 6,
    parameter int MAX_INSN_BYTES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         core_insn_start,
    input  logic         core_mcycle_start,
    input  logic [2:0]   core_mcycle_type,
    input  logic         core_insn_byte_valid,
    input  logic [7:0]   core_insn_byte,
    input  logic [127:0] core_regs,
    output logic         z80fi_valid,
    output logic [31:0]  z80fi_insn,
    output logic [2:0]   z80fi_insn_len,
    output logic [127:0] z80fi_regs_in,
    output logic [127:0] z80fi_regs_out,
    output logic [2:0]   z80fi_mcycle_type1,
    output logic [2:0]   z80fi_mcycle_type2,
    output logic [2:0]   z80fi_mcycle_type3,
    output logic [2:0]   z80fi_mcycle_type4,
    output logic [2:0]   z80fi_mcycle_type5,
    output logic [2:0]   z80fi_mcycle_type6,
    output logic [3:0]   z80fi_tcycles1,
    output logic [3:0]   z80fi_tcycles2,
    output logic [3:0]   z80fi_tcycles3,
    output logic [3:0]   z80fi_tcycles4,
    output logic [3:0]   z80fi_tcycles5,
    output logic [3:0]   z80fi_tcycles6,
    output logic         z80fi_overflow
);

    localparam int SW = (MAX_MCYCLES > 1) ? $clog2(MAX_MCYCLES) : 1;
    localparam int BW = (MAX_INSN_BYTES > 1) ? $clog2(MAX_INSN_BYTES) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(MAX_MCYCLES - 1);
    localparam logic [2:0] LEN_MAX = 3'(MAX_INSN_BYTES);
    localparam logic [2:0] CYCLE_NONE = 3'd0;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;
    logic   emit;

    logic [7:0]    byte_q [MAX_INSN_BYTES];
    logic [2:0]    len_q;
    logic [2:0]    type_q [MAX_MCYCLES];
    logic [3:0]    tcnt_q [MAX_MCYCLES];
    logic [SW-1:0] idx_q;
    logic [SW-1:0] idx_nxt;
    logic          frozen_q;
    logic          ovf_q;
    logic [127:0]  regs_in_q;

    logic [31:0]   cur_insn;
    logic [2:0]    cur_type [6];
    logic [3:0]    cur_tcnt [6];

    logic          valid_q;
    logic [31:0]   rec_insn_q;
    logic [2:0]    rec_len_q;
    logic [127:0]  rec_regs_in_q;
    logic [127:0]  rec_regs_out_q;
    logic [2:0]    rec_type_q [6];
    logic [3:0]    rec_tcnt_q [6];
    logic          rec_ovf_q;

    assign idx_nxt = idx_q + SW'(1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: if (core_insn_start) state_d = RUN;
            RUN:  emit = core_insn_start;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            len_q     <= '0;
            frozen_q  <= 1'b0;
            ovf_q     <= 1'b0;
            regs_in_q <= '0;
            for (int i = 0; i < MAX_INSN_BYTES; i++) byte_q[i] <= '0;
            for (int i = 0; i < MAX_MCYCLES; i++) begin
                type_q[i] <= CYCLE_NONE;
                tcnt_q[i] <= '0;
            end
        end else if (core_insn_start) begin
            // New capture starts here; any byte strobed now is its first byte.
            regs_in_q <= core_regs;
            idx_q     <= '0;
            frozen_q  <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 1; i < MAX_INSN_BYTES; i++) byte_q[i] <= '0;
            for (int i = 1; i < MAX_MCYCLES; i++) begin
                type_q[i] <= CYCLE_NONE;
                tcnt_q[i] <= '0;
            end
            type_q[0] <= core_mcycle_type;
            tcnt_q[0] <= 4'd1;
            if (core_insn_byte_valid) begin
                byte_q[0] <= core_insn_byte;
                len_q     <= 3'd1;
            end else begin
                byte_q[0] <= '0;
                len_q     <= '0;
            end
        end else if (state_q == RUN) begin
            if (core_mcycle_start) begin
                if (!frozen_q) begin
                    if (idx_q == LAST_SLOT) begin
                        ovf_q    <= 1'b1;
                        frozen_q <= 1'b1;
                    end else begin
                        idx_q           <= idx_nxt;
                        type_q[idx_nxt] <= core_mcycle_type;
                        tcnt_q[idx_nxt] <= 4'd1;
                    end
                end
            end else if (!frozen_q && tcnt_q[idx_q] != 4'hF) begin
                tcnt_q[idx_q] <= tcnt_q[idx_q] + 4'd1;
            end
            if (core_insn_byte_valid) begin
                if (len_q == LEN_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    byte_q[len_q[BW-1:0]] <= core_insn_byte;
                    len_q                 <= len_q + 3'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_insn
        if (k < MAX_INSN_BYTES) begin : g_on
            assign cur_insn[8*k +: 8] = byte_q[k];
        end else begin : g_off
            assign cur_insn[8*k +: 8] = 8'h00;
        end
    end

    for (genvar k = 0; k < 6; k++) begin : g_slot
        if (k < MAX_MCYCLES) begin : g_on
            assign cur_type[k] = type_q[k];
            assign cur_tcnt[k] = tcnt_q[k];
        end else begin : g_off
            assign cur_type[k] = CYCLE_NONE;
            assign cur_tcnt[k] = 4'd0;
        end
    end

    // Record registers hold until the next emit so consumers can sample late.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= 1'b0;
            rec_insn_q     <= '0;
            rec_len_q      <= '0;
            rec_regs_in_q  <= '0;
            rec_regs_out_q <= '0;
            rec_ovf_q      <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                rec_type_q[k] <= CYCLE_NONE;
                rec_tcnt_q[k] <= '0;
            end
        end else begin
            valid_q <= emit;
            if (emit) begin
                rec_insn_q     <= cur_insn;
                rec_len_q      <= len_q;
                rec_regs_in_q  <= regs_in_q;
                rec_regs_out_q <= core_regs;
                rec_ovf_q      <= ovf_q;
                for (int k = 0; k < 6; k++) begin
                    rec_type_q[k] <= cur_type[k];
                    rec_tcnt_q[k] <= cur_tcnt[k];
                end
            end
        end
    end

    assign z80fi_valid        = valid_q;
    assign z80fi_insn         = rec_insn_q;
    assign z80fi_insn_len     = rec_len_q;
    assign z80fi_regs_in      = rec_regs_in_q;
    assign z80fi_regs_out     = rec_regs_out_q;
    assign z80fi_overflow     = rec_ovf_q;
    assign z80fi_mcycle_type1 = rec_type_q[0];
    assign z80fi_mcycle_type2 = rec_type_q[1];
    assign z80fi_mcycle_type3 = rec_type_q[2];
    assign z80fi_mcycle_type4 = rec_type_q[3];
    assign z80fi_mcycle_type5 = rec_type_q[4];
    assign z80fi_mcycle_type6 = rec_type_q[5];
    assign z80fi_tcycles1     = rec_tcnt_q[0];
    assign z80fi_tcycles2     = rec_tcnt_q[1];
    assign z80fi_tcycles3     = rec_tcnt_q[2];
    assign z80fi_tcycles4     = rec_tcnt_q[3];
    assign z80fi_tcycles5     = rec_tcnt_q[4];
    assign z80fi_tcycles6     = rec_tcnt_q[5];

endmodule

// File: tb/tb_z80fi_recorder.sv
// Directed bench for z80fi_recorder: each scenario task drives a short
// instruction stream and checks the emitted record against hand values.
module tb_z80fi_recorder;

    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] M1   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] IORD = 3'd4;
    localparam logic [2:0] IOWR = 3'd5;
    localparam logic [2:0] INTL = 3'd7;

    localparam logic [127:0] RA = {16'h0100, 16'hFFFE, 16'h0000, 16'h0000,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    localparam logic [127:0] RB = {16'h0101, 16'hFFFE, 16'h0000, 16'h0000,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h56, 8'h78, 8'h12, 8'h34};
    localparam logic [127:0] RC = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] RD_ = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    localparam logic [127:0] RE = 128'h0000_0000_0000_0000_0000_0000_0000_00E1;
    localparam logic [127:0] RF = 128'h0000_0000_0000_0000_0000_0000_0000_00F2;
    localparam logic [127:0] RG = 128'h0000_0000_0000_0000_0000_0000_0000_0C03;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         core_insn_start = 1'b0;
    logic         core_mcycle_start = 1'b0;
    logic [2:0]   core_mcycle_type = 3'd0;
    logic         core_insn_byte_valid = 1'b0;
    logic [7:0]   core_insn_byte = 8'h00;
    logic [127:0] core_regs = '0;
    logic         z80fi_valid;
    logic [31:0]  z80fi_insn;
    logic [2:0]   z80fi_insn_len;
    logic [127:0] z80fi_regs_in;
    logic [127:0] z80fi_regs_out;
    logic [2:0]   z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3;
    logic [2:0]   z80fi_mcycle_type4, z80fi_mcycle_type5, z80fi_mcycle_type6;
    logic [3:0]   z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3;
    logic [3:0]   z80fi_tcycles4, z80fi_tcycles5, z80fi_tcycles6;
    logic         z80fi_overflow;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    z80fi_recorder dut (
        .clk                  (clk),
        .reset                (reset),
        .core_insn_start      (core_insn_start),
        .core_mcycle_start    (core_mcycle_start),
        .core_mcycle_type     (core_mcycle_type),
        .core_insn_byte_valid (core_insn_byte_valid),
        .core_insn_byte       (core_insn_byte),
        .core_regs            (core_regs),
        .z80fi_valid          (z80fi_valid),
        .z80fi_insn           (z80fi_insn),
        .z80fi_insn_len       (z80fi_insn_len),
        .z80fi_regs_in        (z80fi_regs_in),
        .z80fi_regs_out       (z80fi_regs_out),
        .z80fi_mcycle_type1   (z80fi_mcycle_type1),
        .z80fi_mcycle_type2   (z80fi_mcycle_type2),
        .z80fi_mcycle_type3   (z80fi_mcycle_type3),
        .z80fi_mcycle_type4   (z80fi_mcycle_type4),
        .z80fi_mcycle_type5   (z80fi_mcycle_type5),
        .z80fi_mcycle_type6   (z80fi_mcycle_type6),
        .z80fi_tcycles1       (z80fi_tcycles1),
        .z80fi_tcycles2       (z80fi_tcycles2),
        .z80fi_tcycles3       (z80fi_tcycles3),
        .z80fi_tcycles4       (z80fi_tcycles4),
        .z80fi_tcycles5       (z80fi_tcycles5),
        .z80fi_tcycles6       (z80fi_tcycles6),
        .z80fi_overflow       (z80fi_overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (z80fi_valid === 1'b1) vcount++;

    // One T-state: drive inputs, let the edge happen, settle 1 time unit.
    task automatic cyc(input logic is, input logic ms, input logic [2:0] mt,
                       input logic bv, input logic [7:0] b);
        core_insn_start      = is;
        core_mcycle_start    = ms;
        core_mcycle_type     = mt;
        core_insn_byte_valid = bv;
        core_insn_byte       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, NONE, 1'b0, 8'h00);
    endtask

    task automatic term(input logic [127:0] r);
        core_regs = r;
        cyc(1'b1, 1'b1, M1, 1'b0, 8'h00);
    endtask

    // One M-cycle of nt T-states, optional byte strobe on T2.
    task automatic mcyc(input logic first, input logic [2:0] mt, input int nt,
                        input logic bv, input logic [7:0] b);
        for (int t = 0; t < nt; t++)
            cyc(first && (t == 0), t == 0, mt, bv && (t == 1), b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_regs = RC;
        cyc(1'b1, 1'b1, M1, 1'b1, 8'hAA);
        cyc(1'b0, 1'b1, RD, 1'b1, 8'hBB);
        reset = 1'b0;
        idle();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", z80fi_valid); end
        checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL rst_insn got %h want 0", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL rst_len got %0d want 0", z80fi_insn_len); end
        checks++; if (z80fi_mcycle_type1 !== NONE) begin errors++; $display("FAIL rst_type1 got %0d want 0", z80fi_mcycle_type1); end
        checks++; if (z80fi_tcycles1 !== 4'd0) begin errors++; $display("FAIL rst_t1 got %0d want 0", z80fi_tcycles1); end
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", z80fi_overflow); end
        checks++; if (z80fi_regs_in !== 128'h0) begin errors++; $display("FAIL rst_regs_in got %h want 0", z80fi_regs_in); end
        checks++; if (z80fi_regs_out !== 128'h0) begin errors++; $display("FAIL rst_regs_out got %h want 0", z80fi_regs_out); end
    endtask

    task automatic test_nop();
        do_reset();
        core_regs = RC;
        cyc(1'b1, 1'b1, M1, 1'b0, 8'h00);
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL nop_first_start got %b want 0", z80fi_valid); end
        cyc(1'b0, 1'b0, M1, 1'b1, 8'h00);
        idle();
        idle();
        term(RD_);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL nop_valid got %b want 1", z80fi_valid); end
        checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL nop_insn got %h want 0", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL nop_len got %0d want 1", z80fi_insn_len); end
        checks++; if (z80fi_mcycle_type1 !== M1) begin errors++; $display("FAIL nop_type1 got %0d want %0d", z80fi_mcycle_type1, M1); end
        checks++; if (z80fi_tcycles1 !== 4'd4) begin errors++; $display("FAIL nop_t1 got %0d want 4", z80fi_tcycles1); end
        checks++; if (z80fi_mcycle_type2 !== NONE) begin errors++; $display("FAIL nop_type2 got %0d want 0", z80fi_mcycle_type2); end
        checks++; if (z80fi_tcycles2 !== 4'd0) begin errors++; $display("FAIL nop_t2 got %0d want 0", z80fi_tcycles2); end
        checks++; if (z80fi_regs_in !== RC) begin errors++; $display("FAIL nop_regs_in got %h want %h", z80fi_regs_in, RC); end
        idle();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL nop_pulse_width got %b want 0", z80fi_valid); end
        checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL nop_hold_len got %0d want 1", z80fi_insn_len); end
        checks++; if (z80fi_tcycles1 !== 4'd4) begin errors++; $display("FAIL nop_hold_t1 got %0d want 4", z80fi_tcycles1); end
    endtask

    task automatic test_ex_de_hl();
        do_reset();
        core_regs = RA;
        mcyc(1'b1, M1, 4, 1'b1, 8'hEB);
        term(RB);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ex_valid got %b want 1", z80fi_valid); end
        checks++; if (z80fi_regs_in !== RA) begin errors++; $display("FAIL ex_regs_in got %h want %h", z80fi_regs_in, RA); end
        checks++; if (z80fi_regs_out !== RB) begin errors++; $display("FAIL ex_regs_out got %h want %h", z80fi_regs_out, RB); end
        checks++; if (z80fi_insn !== 32'h000000EB) begin errors++; $display("FAIL ex_insn got %h want 000000eb", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL ex_len got %0d want 1", z80fi_insn_len); end
        checks++; if (z80fi_tcycles1 !== 4'd4) begin errors++; $display("FAIL ex_t1 got %0d want 4", z80fi_tcycles1); end
    endtask

    task automatic test_ld_a_nn();
        do_reset();
        core_regs = RC;
        mcyc(1'b1, M1, 4, 1'b1, 8'h3A);
        mcyc(1'b0, RD, 3, 1'b1, 8'h34);
        mcyc(1'b0, RD, 3, 1'b1, 8'h12);
        mcyc(1'b0, RD, 3, 1'b0, 8'h00);
        term(RD_);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %b want 1", z80fi_valid); end
        checks++; if (z80fi_insn !== 32'h0012343A) begin errors++; $display("FAIL ld_insn got %h want 0012343a", z80fi_insn); end
        checks++; if (z80fi_insn_len !== 3'd3) begin errors++; $display("FAIL ld_len got %0d want 3", z80fi_insn_len); end
        checks++; if ({z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4} !== {M1, RD, RD, RD})
            begin errors++; $display("FAIL ld_types1to4 got %0d %0d %0d %0d want 1 2 2 2", z80fi_mcycle_type1, z80fi_mcycle_type2, z80fi_mcycle_type3, z80fi_mcycle_type4); end
        checks++; if ({z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4} !== 16'h4333)
            begin errors++; $display("FAIL ld_tcycles1to4 got %0d %0d %0d %0d want 4 3 3 3", z80fi_tcycles1, z80fi_tcycles2, z80fi_tcycles3, z80fi_tcycles4); end
        checks++; if ({z80fi_mcycle_type5, z80fi_mcycle_type6, z80fi_tcycles5, z80fi_tcycles6} !== 14'h0)
            begin errors++; $display("FAIL ld_unused_slots got %0d/%0d %0d/%0d want 0/0 0/0", z80fi_mcycle_type5, z80fi_tcycles5, z80fi_mcycle_type6, z80fi_tcycles6); end
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL ld_ovf got %b want 0", z80fi_overflow); end
    endtask

    task automatic test_full_no_overflow();
        do_reset();
        core_regs = RC;
        mcyc(1'b1, M1, 4, 1'b1, 8'hDD);
        mcyc(1'b0, RD, 3, 1'b1, 8'h21);
        mcyc(1'b0, RD, 3, 1'b1, 8'h34);
        mcyc(1'b0, RD, 3, 1'b1, 8'h12);
        mcyc(1'b0, WR, 3, 1'b0, 8'h00);
        mcyc(1'b0, WR, 5, 1'b0, 8'h00);
        term(RD_);
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL full_ovf got %b want 0", z80fi_overflow); end
        checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL full_len got %0d want 4", z80fi_insn_len); end
        checks++; if (z80fi_insn !== 32'h123421DD) begin errors++; $display("FAIL full_insn got %h want 123421dd", z80fi_insn); end
        checks++; if (z80fi_mcycle_type6 !== WR) begin errors++; $display("FAIL full_type6 got %0d want %0d", z80fi_mcycle_type6, WR); end
        checks++; if (z80fi_tcycles6 !== 4'd5) begin errors++; $display("FAIL full_t6 got %0d want 5", z80fi_tcycles6); end
    endtask

    task automatic test_overflow();
        do_reset();
        core_regs = RC;
        mcyc(1'b1, M1, 4, 1'b1, 8'hDD);
        mcyc(1'b0, RD, 3, 1'b1, 8'hCB);
        mcyc(1'b0, RD, 3, 1'b1, 8'h05);
        mcyc(1'b0, WR, 3, 1'b1, 8'h46);
        mcyc(1'b0, IORD, 3, 1'b1, 8'h99);
        mcyc(1'b0, IOWR, 3, 1'b0, 8'h00);
        mcyc(1'b0, INTL, 5, 1'b0, 8'h00);
        term(RD_);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", z80fi_valid); end
        checks++; if (z80fi_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", z80fi_overflow); end
        checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL ovf_len got %0d want 4", z80fi_insn_len); end
        checks++; if (z80fi_insn !== 32'h4605CBDD) begin errors++; $display("FAIL ovf_insn got %h want 4605cbdd", z80fi_insn); end
        checks++; if (z80fi_mcycle_type5 !== IORD) begin errors++; $display("FAIL ovf_type5 got %0d want %0d", z80fi_mcycle_type5, IORD); end
        checks++; if (z80fi_mcycle_type6 !== IOWR) begin errors++; $display("FAIL ovf_type6 got %0d want %0d", z80fi_mcycle_type6, IOWR); end
        checks++; if (z80fi_tcycles6 !== 4'd3) begin errors++; $display("FAIL ovf_t6_frozen got %0d want 3", z80fi_tcycles6); end
        checks++; if (z80fi_tcycles1 !== 4'd4) begin errors++; $display("FAIL ovf_t1 got %0d want 4", z80fi_tcycles1); end
        idle();
        term(RC);
        checks++; if (z80fi_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", z80fi_overflow); end
    endtask

    task automatic test_saturate();
        do_reset();
        core_regs = RC;
        mcyc(1'b1, M1, 20, 1'b0, 8'h00);
        term(RD_);
        checks++; if (z80fi_tcycles1 !== 4'd15) begin errors++; $display("FAIL sat_t1 got %0d want 15", z80fi_tcycles1); end
        checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL sat_len got %0d want 0", z80fi_insn_len); end
    endtask

    task automatic test_reset_mid();
        int v0;
        do_reset();
        core_regs = RA;
        mcyc(1'b1, M1, 2, 1'b1, 8'h3E);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        v0 = vcount;
        core_regs = RC;
        mcyc(1'b1, M1, 4, 1'b0, 8'h00);
        checks++; if (vcount - v0 !== 0 || z80fi_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_early_valid got %0d pulses want 0", vcount - v0); end
        term(RD_);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid got %b want 1", z80fi_valid); end
        checks++; if (z80fi_regs_in !== RC) begin errors++; $display("FAIL rmid_regs_in got %h want %h", z80fi_regs_in, RC); end
        checks++; if (z80fi_regs_out !== RD_) begin errors++; $display("FAIL rmid_regs_out got %h want %h", z80fi_regs_out, RD_); end
        checks++; if (z80fi_tcycles1 !== 4'd4) begin errors++; $display("FAIL rmid_t1 got %0d want 4", z80fi_tcycles1); end
        idle();
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL rmid_pulse_count got %0d want 1", vcount - v0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        term(RE);
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got %b want 0", z80fi_valid); end
        term(RF);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b want 1", z80fi_valid); end
        checks++; if (z80fi_tcycles1 !== 4'd1) begin errors++; $display("FAIL b2b_t1_a got %0d want 1", z80fi_tcycles1); end
        checks++; if (z80fi_regs_in !== RE || z80fi_regs_out !== RF) begin errors++; $display("FAIL b2b_regs_a got %h/%h want %h/%h", z80fi_regs_in, z80fi_regs_out, RE, RF); end
        term(RG);
        checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %b want 1", z80fi_valid); end
        checks++; if (z80fi_tcycles1 !== 4'd1) begin errors++; $display("FAIL b2b_t1_b got %0d want 1", z80fi_tcycles1); end
        checks++; if (z80fi_regs_in !== RF || z80fi_regs_out !== RG) begin errors++; $display("FAIL b2b_regs_b got %h/%h want %h/%h", z80fi_regs_in, z80fi_regs_out, RF, RG); end
        idle();
        checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", z80fi_valid); end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_ex_de_hl();
        test_ld_a_nn();
        test_full_no_overflow();
        test_overflow();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
